// File: rtl/seq_pkg.sv
// Shared definitions for the single-bit sequence link.
// The state codes are visible on debug ports (state_out) and are shared
// with the sequence detector, so they are fixed 2-bit constants rather
// than an enum whose encoding a tool might choose.
package seq_pkg;

    typedef logic [1:0] seq_state_t;

    localparam seq_state_t ST_IDLE  = 2'b00;
    localparam seq_state_t ST_SHIFT = 2'b01;
    localparam seq_state_t ST_GAP   = 2'b10;
    localparam seq_state_t ST_DONE  = 2'b11;

endpackage

// File: rtl/seq_piso_shift.sv
// Parallel-in, serial-out shift register, MSB first.
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        parallel load of din (has priority over shift)
//   shift       shift left by one, zero filled
//   din         parallel load value
//   q           full register contents; q[PAT_W-1] is the current bit
module seq_piso_shift #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic [PAT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (load) begin
            q <= din;
        end else if (shift) begin
            q <= {q[PAT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_gen_serial.sv
// Serial pattern transmitter: sends a latched PAT_W-bit pattern MSB first,
// one bit per clock, repeat_cnt times, with gap_len idle cycles between
// repetitions.
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   start        begin a run; only looked at in IDLE
//   abort        synchronous cancel; beats every other input, no done pulse
//   pattern      pattern to send, MSB first
//   repeat_cnt   number of repetitions (0 = go straight to DONE)
//   gap_len      idle cycles between repetitions (0 = back-to-back)
//   seq_out      serial data, forced 0 when seq_valid is low
//   seq_valid    seq_out holds a pattern bit this cycle
//   busy         high in SHIFT and GAP
//   done         single-cycle pulse when the last repetition has been sent
//   state_out    current FSM state (debug)
// Handshake: there is no back-pressure. A run is accepted on any edge that
// sees start=1, abort=0 while in IDLE; seq_valid then marks each data bit and
// the consumer must take every bit on the cycle it is offered.
module seq_gen_serial
    import seq_pkg::*;
#(
    parameter int PAT_W = 4,
    parameter int CNT_W = 4,
    parameter int GAP_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    output logic             seq_out,
    output logic             seq_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       state_out
);

    localparam int              BIT_W    = $clog2(PAT_W);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(PAT_W - 1);

    seq_state_t       state_q, state_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [CNT_W-1:0] rep_q, rep_d;     // repetitions still to send after the current one
    logic [GAP_W-1:0] glen_q, glen_d;   // latched gap length
    logic [GAP_W-1:0] gcnt_q, gcnt_d;   // gap cycles still to spend, including this one
    logic [PAT_W-1:0] pat_q, pat_d;     // latched pattern, reloaded every repetition

    logic             piso_load, piso_shift;
    logic [PAT_W-1:0] piso_din, piso_q;
    logic             next_bit;

    logic seq_out_d, seq_valid_d, busy_d, done_d;

    // The shift register holds the pattern advanced so that its MSB is the
    // bit currently on seq_out; the following bit is therefore q[PAT_W-2].
    seq_piso_shift #(.PAT_W(PAT_W)) u_piso (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (piso_load),
        .shift (piso_shift),
        .din   (piso_din),
        .q     (piso_q)
    );

    // State and counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bit_q   <= '0;
            rep_q   <= '0;
            glen_q  <= '0;
            gcnt_q  <= '0;
            pat_q   <= '0;
        end else begin
            state_q <= state_d;
            bit_q   <= bit_d;
            rep_q   <= rep_d;
            glen_q  <= glen_d;
            gcnt_q  <= gcnt_d;
            pat_q   <= pat_d;
        end
    end

    // Next-state, counter and shift-register control
    always_comb begin
        state_d    = state_q;
        bit_d      = bit_q;
        rep_d      = rep_q;
        glen_d     = glen_q;
        gcnt_d     = gcnt_q;
        pat_d      = pat_q;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        piso_din   = pat_q;
        next_bit   = 1'b0;

        if (abort) begin
            state_d = ST_IDLE;
            bit_d   = '0;
            rep_d   = '0;
            gcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pat_d     = pattern;
                        glen_d    = gap_len;
                        bit_d     = '0;
                        piso_load = 1'b1;
                        piso_din  = pattern;
                        if (repeat_cnt != '0) begin
                            state_d  = ST_SHIFT;
                            rep_d    = repeat_cnt - CNT_W'(1);
                            next_bit = pattern[PAT_W-1];
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end

                ST_SHIFT: begin
                    if (bit_q == BIT_LAST) begin
                        bit_d = '0;
                        if (rep_q == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            rep_d     = rep_q - CNT_W'(1);
                            piso_load = 1'b1;
                            if (glen_q == '0) begin
                                // back-to-back: next repetition's MSB without a bubble
                                next_bit = pat_q[PAT_W-1];
                            end else begin
                                state_d = ST_GAP;
                                gcnt_d  = glen_q;
                            end
                        end
                    end else begin
                        bit_d      = bit_q + BIT_W'(1);
                        piso_shift = 1'b1;
                        next_bit   = piso_q[PAT_W-2];
                    end
                end

                ST_GAP: begin
                    if (gcnt_q <= GAP_W'(1)) begin
                        state_d  = ST_SHIFT;
                        gcnt_d   = '0;
                        next_bit = piso_q[PAT_W-1];
                    end else begin
                        gcnt_d = gcnt_q - GAP_W'(1);
                    end
                end

                default: begin  // ST_DONE
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Output decode of the upcoming state; registered below so every
    // output is a flop and lines up with state_out.
    always_comb begin
        seq_valid_d = (state_d == ST_SHIFT);
        seq_out_d   = seq_valid_d & next_bit;
        busy_d      = (state_d == ST_SHIFT) || (state_d == ST_GAP);
        done_d      = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_out   <= 1'b0;
            seq_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            seq_out   <= seq_out_d;
            seq_valid <= seq_valid_d;
            busy      <= busy_d;
            done      <= done_d;
        end
    end

    assign state_out = state_q;

endmodule

// File: tb/tb_seq_gen_serial.sv
module tb_seq_gen_serial;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       abort;
    logic [3:0] pattern;
    logic [3:0] repeat_cnt;
    logic [2:0] gap_len;
    logic       seq_out;
    logic       seq_valid;
    logic       busy;
    logic       done;
    logic [1:0] state_out;

    int n_cmp = 0;
    int n_err = 0;

    // expected per-cycle vector: {state, done, busy, valid, out}
    logic [5:0] exp_q[$];

    // loopback detector model state
    logic [3:0] det_target;
    logic [3:0] det_win;
    int         det_seen;
    int         det_count;

    seq_gen_serial #(.PAT_W(4), .CNT_W(4), .GAP_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .abort      (abort),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .seq_out    (seq_out),
        .seq_valid  (seq_valid),
        .busy       (busy),
        .done       (done),
        .state_out  (state_out)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_cmp++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    function automatic logic [5:0] obs_vec();
        return {state_out, done, busy, seq_valid, seq_out};
    endfunction

    // ---------------- reference model ----------------
    // Timeline of a run straight from the transmit rules: R copies of the
    // pattern MSB first, G idle cycles between copies, one DONE cycle, then idle.
    task automatic build_expected(input logic [3:0] p, input int r, input int g);
        exp_q.delete();
        for (int rep = 0; rep < r; rep++) begin
            for (int b = 3; b >= 0; b--) exp_q.push_back({2'b01, 1'b0, 1'b1, 1'b1, p[b]});
            if (rep < r - 1)
                for (int k = 0; k < g; k++) exp_q.push_back({2'b10, 1'b0, 1'b1, 1'b0, 1'b0});
        end
        exp_q.push_back({2'b11, 1'b1, 1'b0, 1'b0, 1'b0});
        exp_q.push_back({2'b00, 1'b0, 1'b0, 1'b0, 1'b0});
    endtask

    task automatic detect_step();
        if (seq_valid) begin
            det_win = {det_win[2:0], seq_out};
            det_seen++;
            if (det_seen >= 4 && det_win == det_target) begin
                det_count++;
                det_seen = 0;
            end
        end
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        start      = 1'b0;
        abort      = 1'b0;
        pattern    = 4'h0;
        repeat_cnt = 4'h0;
        gap_len    = 3'h0;
    endtask

    // Launch one run and compare every cycle until the idle cycle after DONE.
    // With disturb set, start/pattern/count/gap are scrambled while the run
    // is in flight; none of it may change the output.
    task automatic run_gen(input string tag, input logic [3:0] p, input int r, input int g,
                           input bit disturb);
        logic [5:0] e;
        build_expected(p, r, g);
        @(negedge clk);
        pattern    = p;
        repeat_cnt = 4'(r);
        gap_len    = 3'(g);
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check(tag, 32'(obs_vec()), 32'(e));
            detect_step();
            if (disturb && exp_q.size() > 1) begin
                start      = 1'($urandom_range(0, 1));
                pattern    = 4'($urandom);
                repeat_cnt = 4'($urandom);
                gap_len    = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            if (exp_q.size() > 0) @(negedge clk);
        end
        idle_inputs();
    endtask

    task automatic expect_idle(input string tag, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check(tag, 32'(obs_vec()), 32'd0);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [5:0] e;
        int         done_seen;
        logic [3:0] rp;
        int         rr, rg;

        idle_inputs();
        det_target = 4'b1011;
        det_win    = '0;
        det_seen   = 0;
        det_count  = 0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", 32'(obs_vec()), 32'd0);
        rst_n = 1'b1;
        expect_idle("idle_after_reset", 2);

        // back-to-back repetitions, doubles as the loopback detection run
        det_count = 0; det_seen = 0;
        run_gen("b2b_1011", 4'b1011, 3, 0, 1'b0);
        check("loopback_detections", 32'(det_count), 32'd3);

        // gapped repetitions
        run_gen("gap_1010", 4'b1010, 2, 2, 1'b0);

        // zero repetitions: straight to DONE
        run_gen("zero_reps", 4'b1111, 0, 3, 1'b0);

        // abort on the 6th bit of a 3-rep run
        build_expected(4'b1011, 3, 0);
        @(negedge clk);
        pattern = 4'b1011; repeat_cnt = 4'd3; gap_len = 3'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            e = exp_q.pop_front();
            check("abort_pre", 32'(obs_vec()), 32'(e));
            if (i < 5) @(negedge clk);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_idle", 32'(obs_vec()), 32'd0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done) done_seen++;
            check("abort_quiet", 32'(obs_vec()), 32'd0);
        end
        check("abort_no_done", 32'(done_seen), 32'd0);

        // start and abort together in IDLE: abort wins
        pattern = 4'b1100; repeat_cnt = 4'd1; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("start_abort_same_edge", 32'(obs_vec()), 32'd0);
        expect_idle("start_abort_after", 2);

        // fresh run after abort
        run_gen("fresh_after_abort", 4'b1011, 3, 0, 1'b0);

        // inputs disturbed mid-run must be ignored
        run_gen("disturbed_run", 4'b1011, 3, 0, 1'b1);
        run_gen("disturbed_gap", 4'b0110, 3, 3, 1'b1);

        // start held high: back-to-back runs with one idle cycle between
        build_expected(4'b1001, 1, 0);
        exp_q.push_back({2'b01, 1'b0, 1'b1, 1'b1, 1'b1});
        @(negedge clk);
        pattern = 4'b1001; repeat_cnt = 4'd1; gap_len = 3'd0; start = 1'b1;
        @(negedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("start_held", 32'(obs_vec()), 32'(e));
            if (exp_q.size() > 0) @(negedge clk);
        end
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("start_held_settled", 32'(obs_vec()), 32'd0);

        // asynchronous reset mid-run
        @(negedge clk);
        pattern = 4'b1111; repeat_cnt = 4'd4; gap_len = 3'd1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_reset_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1 check("async_reset", 32'(obs_vec()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_inputs();
        expect_idle("post_reset_idle", 2);

        // randomized runs against the model
        for (int n = 0; n < 15; n++) begin
            rp = 4'($urandom);
            rr = int'($urandom_range(0, 4));
            rg = int'($urandom_range(0, 3));
            run_gen($sformatf("rand_%0d", n), rp, rr, rg, 1'($urandom_range(0, 1)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
